// File: rtl/aes192_dec_key_buffer.sv
// Captures the NR+1 forward-expanded round keys and replays them in reverse round
// order over valid/ready. Define AES192_DEC_INVMIX_EN to emit equivalent-inverse-cipher keys.
module aes192_dec_key_buffer #(
  parameter int NR = 12,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [KW-1:0] in_key,
  input  logic          dec_start,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [KW-1:0] out_key,
  output logic [3:0]    out_round,
  output logic          out_last,
  output logic          key_loaded,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, LOAD, READY, SERVE} state_t;

  localparam logic [3:0] NR_IDX = 4'(NR);

  state_t          state_q, state_d;
  logic [3:0]      wr_ptr_q, wr_ptr_d;
  logic [3:0]      rd_ptr_q, rd_ptr_d;
  logic            out_valid_d, key_loaded_d;
  logic [KW-1:0]   out_key_d;
  logic [3:0]      out_round_d;
  logic            mem_we;
  logic [3:0]      mem_addr;
  logic [3:0]      rd_idx;
  logic [KW-1:0]   rd_key;
  logic [KW-1:0]   key_mem [NR+1];

`ifdef AES192_DEC_INVMIX_EN
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] p, x;
    p = '0;
    x = b;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  function automatic logic [KW-1:0] inv_mix_key(input logic [KW-1:0] k);
    logic [KW-1:0] r;
    r = k;
    for (int c = 0; c < KW / 32; c++) r[KW-1-32*c -: 32] = inv_mix_col(k[KW-1-32*c -: 32]);
    return r;
  endfunction
`endif

  // Key to present next: key[NR] when starting a replay, otherwise the one below rd_ptr.
  assign rd_idx = (state_q == SERVE && rd_ptr_q != 4'd0) ? rd_ptr_q - 4'd1 : NR_IDX;

  always_comb begin
    rd_key = key_mem[rd_idx];
`ifdef AES192_DEC_INVMIX_EN
    if (rd_idx != 4'd0 && rd_idx != NR_IDX) rd_key = inv_mix_key(key_mem[rd_idx]);
`endif
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    out_valid_d  = out_valid;
    out_key_d    = out_key;
    out_round_d  = out_round;
    key_loaded_d = key_loaded;
    mem_we       = 1'b0;
    mem_addr     = wr_ptr_q;

    if (load_start) begin
      state_d      = LOAD;
      key_loaded_d = 1'b0;
      out_valid_d  = 1'b0;
      mem_we       = in_valid;
      mem_addr     = 4'd0;
      wr_ptr_d     = in_valid ? 4'd1 : 4'd0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 4'd1;
            if (wr_ptr_q == NR_IDX) begin
              state_d      = READY;
              key_loaded_d = 1'b1;
            end
          end
        end
        READY: begin
          if (dec_start) begin
            state_d     = SERVE;
            out_valid_d = 1'b1;
            out_key_d   = rd_key;
            out_round_d = rd_idx;
            rd_ptr_d    = NR_IDX;
          end
        end
        SERVE: begin
          if (out_valid && out_ready) begin
            if (rd_ptr_q != 4'd0) begin
              rd_ptr_d    = rd_ptr_q - 4'd1;
              out_key_d   = rd_key;
              out_round_d = rd_idx;
            end else begin
              out_valid_d = 1'b0;
              state_d     = READY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_valid  <= 1'b0;
      out_key    <= '0;
      out_round  <= '0;
      key_loaded <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_valid  <= out_valid_d;
      out_key    <= out_key_d;
      out_round  <= out_round_d;
      key_loaded <= key_loaded_d;
    end
  end

  // NOTE: key storage has no reset; key_loaded gates its use, so it can map to plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) key_mem[mem_addr] <= in_key;
  end

  assign out_last = out_valid && (out_round == 4'd0);
  assign busy     = (state_q == LOAD) || (state_q == SERVE);

endmodule

// File: tb/tb_aes192_dec_key_buffer.sv
// Directed bench for aes192_dec_key_buffer: FIPS-197 AES-192 key schedule model,
// table-driven replay checks and hand-written abort/reset sequences.
module tb_aes192_dec_key_buffer;

  typedef struct {
    logic         rdy;
    logic [3:0]   round;
    logic [127:0] key;
    logic         last;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_start, in_valid, dec_start, out_ready;
  logic [127:0] in_key;
  logic         out_valid, out_last, key_loaded, busy;
  logic [127:0] out_key;
  logic [3:0]   out_round;

  int total = 0;
  int bad   = 0;

  logic [127:0] rk       [13];
  logic [127:0] exp_key  [13];
  logic [127:0] load_buf [13];
  vec_t         vec      [64];
  int           nvec;

  aes192_dec_key_buffer #(.NR(12), .KW(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .in_valid  (in_valid),
    .in_key    (in_key),
    .dec_start (dec_start),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_key   (out_key),
    .out_round (out_round),
    .out_last  (out_last),
    .key_loaded(key_loaded),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, t, s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
    t = inv;
    s = inv;
    for (int k = 0; k < 4; k++) begin
      t = {t[6:0], t[7]};
      s ^= t;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] model_inv_mix_col(input logic [31:0] a);
    logic [7:0] b [4];
    logic [7:0] m [4][4];
    logic [31:0] r;
    m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
          '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    for (int i = 0; i < 4; i++) b[i] = a[31-8*i -: 8];
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++) r[31-8*row -: 8] ^= gf_mul(m[row][c], b[c]);
    return r;
  endfunction

  function automatic logic [127:0] model_inv_mix_key(input logic [127:0] k);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = model_inv_mix_col(k[127-32*c -: 32]);
    return r;
  endfunction

  task automatic expand_key(input logic [191:0] key);
    logic [31:0] w [52];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-6] ^ t;
    end
    for (int r = 0; r < 13; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_keys();
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_key     = load_buf[0];
    step();
    load_start = 1'b0;
    for (int i = 1; i < 13; i++) begin
      in_key = load_buf[i];
      if (i == 12) check("loaded_before_13th", key_loaded, 0);
      step();
    end
    in_valid = 1'b0;
    check("loaded_after_13th", key_loaded, 1);
  endtask

  task automatic run_table(input string tag);
    dec_start = 1'b1;
    out_ready = 1'b0;
    check({tag, "_no_beat_yet"}, out_valid, 0);
    step();
    dec_start = 1'b0;
    for (int i = 0; i < nvec; i++) begin
      out_ready = vec[i].rdy;
      check($sformatf("%s_%0d_valid", tag, i), out_valid, 1);
      check($sformatf("%s_%0d_round", tag, i), out_round, vec[i].round);
      check($sformatf("%s_%0d_key", tag, i), out_key, vec[i].key);
      check($sformatf("%s_%0d_last", tag, i), out_last, vec[i].last);
      step();
    end
    out_ready = 1'b0;
    check({tag, "_end_valid"}, out_valid, 0);
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_loaded"}, key_loaded, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; load_start = 1'b0; in_valid = 1'b0; dec_start = 1'b0;
    out_ready = 1'b0; in_key = '0;
    expand_key(192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b);
    for (int r = 0; r < 13; r++) begin
      exp_key[r] = rk[r];
`ifdef AES192_DEC_INVMIX_EN
      if (r != 0 && r != 12) exp_key[r] = model_inv_mix_key(rk[r]);
`endif
    end

    step(); step();
    check("rst_valid", out_valid, 0);
    check("rst_key", out_key, 0);
    check("rst_round", out_round, 0);
    check("rst_loaded", key_loaded, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 13; i++) load_buf[i] = rk[i];
    load_keys();
    check("ready_busy", busy, 0);

    // Streaming replay; first and last beats pinned to published key-schedule values.
    nvec = 13;
    for (int i = 0; i < 13; i++) vec[i] = '{1'b1, 4'(12 - i), exp_key[12 - i], i == 12};
    vec[0].key  = 128'he98ba06f448c773c8ecc720401002202;
    vec[12].key = 128'h8e73b0f7da0e6452c810f32b809079e5;
`ifndef AES192_DEC_INVMIX_EN
    vec[11].key = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
`endif
    run_table("stream");

    // out_ready 0,0,1 repeating: each key must hold for the two stalled cycles.
    nvec = 0;
    for (int b = 0; b < 13; b++)
      for (int k = 0; k < 3; k++) begin
        vec[nvec] = '{k == 2, 4'(12 - b), exp_key[12 - b], b == 12};
        nvec++;
      end
    run_table("stall_a");
    run_table("stall_b");

    // Abort a replay after 5 accepted beats.
    dec_start = 1'b1;
    out_ready = 1'b1;
    step();
    dec_start = 1'b0;
    check("serve_busy", busy, 1);
    for (int i = 0; i < 5; i++) step();
    check("abort_pre_round", out_round, 7);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    out_ready  = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_loaded", key_loaded, 0);
    check("abort_busy", busy, 1);
    for (int i = 0; i < 13; i++) begin
      if (i == 4) begin
        in_valid = 1'b0;
        step();
      end
      in_valid  = 1'b1;
      in_key    = rk[i];
      dec_start = (i == 6);
      step();
      check($sformatf("reload_%0d_no_beat", i), out_valid, 0);
    end
    in_valid  = 1'b0;
    dec_start = 1'b0;
    check("reload_loaded", key_loaded, 1);
    dec_start = 1'b1;
    step();
    dec_start = 1'b0;
    check("reload_first_round", out_round, 12);
    check("reload_first_key", out_key, exp_key[12]);

    // Restart a load mid-replay, reach wr_ptr=7, then reset asynchronously.
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_key     = rk[0];
    step();
    load_start = 1'b0;
    check("restart_valid", out_valid, 0);
    for (int i = 1; i < 7; i++) begin
      in_key = rk[i];
      step();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #2;
    check("arst_valid", out_valid, 0);
    check("arst_key", out_key, 0);
    check("arst_round", out_round, 0);
    check("arst_last", out_last, 0);
    check("arst_loaded", key_loaded, 0);
    check("arst_busy", busy, 0);
    step();
    reset     = 1'b1;
    dec_start = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_%0d_valid", i), out_valid, 0);
    end
    dec_start = 1'b0;

`ifdef AES192_DEC_INVMIX_EN
    for (int i = 0; i < 13; i++) load_buf[i] = rk[i];
    load_buf[1][127:96] = 32'h01020304;
    load_keys();
    dec_start = 1'b1;
    out_ready = 1'b1;
    step();
    dec_start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 0)  check("imc_round12", out_key, load_buf[12]);
      if (i == 11) check("imc_col0", out_key[127:96], model_inv_mix_col(32'h01020304));
      if (i == 12) check("imc_round0", out_key, load_buf[0]);
      step();
    end
    out_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes192_dec_key_buffer.md
Name: aes192_dec_key_buffer

Overview:
- Receiving end of the round-key stream from the AES-192 forward key expander.
- Captures the 13 round keys, arriving in round order 0..12, into local storage.
- Replays them in reverse order (12..0) over a valid/ready handshake to the decryption round datapath.
- Keys are retained, so any number of blocks can be decrypted per key load.

Parameters:
- NR, 12, number of cipher rounds; NR+1 keys are stored (10/12/14 legal, 12 for AES-192).
- KW, 128, round-key width in bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  pulse; begins a new key capture (same cycle the expander is started).
- in_valid  in  1  in_key holds the next round key in round order.
- in_key  in  KW  round key from expander.
- dec_start  in  1  pulse; begin reverse replay.
- out_ready  in  1  consumer accepts out_key this cycle.
- out_valid  out  1  out_key/out_round valid.
- out_key  out  KW  round key, registered.
- out_round  out  4  round index of out_key.
- out_last  out  1  high with out_valid when out_round==0.
- key_loaded  out  1  all NR+1 keys captured and not invalidated.
- busy  out  1  state is LOAD or SERVE.

Behaviour:
- States: IDLE, LOAD, READY, SERVE.
- Reset (reset=0, async): state IDLE; wr_ptr=0, rd_ptr=0; out_valid, out_last, key_loaded, busy = 0; out_key = 0, out_round = 0. Storage contents don't care.
- IDLE/READY/SERVE + load_start:
  - Next state LOAD; key_loaded=0; out_valid=0 next cycle (an in-progress replay is aborted, no further beats).
  - If in_valid is also high that cycle, in_key is stored at index 0 and wr_ptr=1; otherwise wr_ptr=0.
- LOAD:
  - Each in_valid writes in_key at wr_ptr, then wr_ptr++. No backpressure; gaps in in_valid are allowed.
  - Write at index NR: next state READY, key_loaded=1 next cycle.
  - load_start in LOAD restarts per the rule above. dec_start ignored. in_valid ignored outside LOAD, except on the load_start cycle.
- READY + dec_start (no load_start):
  - Next state SERVE; next cycle out_valid=1, out_key=key[NR], out_round=NR, rd_ptr=NR.
  - Latency from dec_start to first valid beat: 1 cycle.
- SERVE:
  - out_valid/out_key/out_round are held stable while out_ready=0.
  - On out_valid&out_ready with rd_ptr>0: rd_ptr--, and the next key loads into the output register on the same edge. Zero-bubble streaming: out_valid stays 1.
  - On out_valid&out_ready with rd_ptr==0: out_valid=0, state READY.
  - dec_start in SERVE ignored.
  - load_start has priority over dec_start and over the handshake in every state.
- out_last is combinational: out_valid & (out_round==0).
- busy is combinational from state.

Optional Feature:
- Macro: AES192_DEC_INVMIX_EN.
- Defined: keys for rounds 1..NR-1 pass through InvMixColumns, applied per 32-bit column with GF(2^8) coefficients 0e,0b,0d,09, before loading into out_key (equivalent inverse cipher). Rounds 0 and NR pass unmodified. Latency and handshake are unchanged; the transform sits on the output-register load path.
- Undefined: keys are replayed verbatim.

Test Plan:
- FIPS-197 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b; load 13 keys back-to-back, load_start coincident with the round-0 in_valid. Required: key_loaded=1 on the cycle after the 13th write.
- dec_start with out_ready=1, feature off. Required:
  - Beats start 1 cycle later.
  - Beat 0: out_round=12, out_key=e98ba06f448c773c8ecc720401002202.
  - Beat 11: round 1, 62f8ead2522c6b7bfe0c91f72402f5a5.
  - Beat 12: round 0, 8e73b0f7da0e6452c810f32b809079e5, with out_last=1.
  - 13 consecutive beats, then out_valid=0, state READY.
- out_ready toggled 0,0,1 repeating. Required: every key is held stable while stalled, each key is delivered exactly once in order 12..0, and a second dec_start replays an identical sequence.
- load_start asserted mid-replay after 5 beats. Required: out_valid=0 next cycle, key_loaded=0, busy=1; dec_start ignored until 13 new keys are written.
- Asynchronous reset asserted mid-LOAD (wr_ptr=7). Required: all outputs 0 immediately; after release, dec_start produces no out_valid.
- With AES192_DEC_INVMIX_EN, column 01020304 supplied at round 1. Required: that column of out_key reads InvMixColumns(01020304); rounds 0 and 12 are unchanged.
